// File: rtl/rej_uniform_sampler.sv
// Kyber Parse: turns SHAKE-128 buffers into 256 coefficients below Q by rejection sampling.
// Latency: one triple per cycle; a fully accepting buffer gives done 129 cycles after the handshake.
// Backpressure: in_ready is high only while waiting for a buffer; in_valid is ignored otherwise.
module rej_uniform_sampler #(
    parameter int IN_W   = 3072,
    parameter int N_COEF = 256,
    parameter int Q      = 3329
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:IN_W-1]       Z_in,
    output logic [0:12*N_COEF-1]  poly,
    output logic [8:0]            coef_cnt,
    output logic                  need_more,
    output logic                  busy,
    output logic                  done
);

    localparam int NTRIP = IN_W / 24;
    localparam int PTR_W = (NTRIP > 1) ? $clog2(NTRIP) : 1;
    localparam logic [8:0]       NC       = 9'(N_COEF);
    localparam logic [11:0]      Q12      = 12'(Q);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NTRIP - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUF, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [0:IN_W-1]    zbuf;
    logic [PTR_W-1:0]   ptr;

    logic [23:0] triple;
    logic [7:0]  b0, b1, b2;
    logic [11:0] d1, d2;
    logic        acc1, acc2, last_trip;
    logic [8:0]  cnt1, cnt2;

    // Byte 3*ptr is the most significant byte of the selected triple.
    always_comb begin
        triple    = zbuf[24*int'(ptr) +: 24];
        b0        = triple[23:16];
        b1        = triple[15:8];
        b2        = triple[7:0];
        d1        = {b1[3:0], b0};
        d2        = {b2, b1[7:4]};
        acc1      = (d1 < Q12) && (coef_cnt < NC);
        cnt1      = coef_cnt + {8'd0, acc1};
        acc2      = (d2 < Q12) && (cnt1 < NC);
        cnt2      = cnt1 + {8'd0, acc2};
        last_trip = (ptr == PTR_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = WAIT_BUF;
            end
            WAIT_BUF: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SAMPLE;
            end
            SAMPLE: begin
                // Filling the polynomial wins over running out of triples.
                if (cnt2 == NC)     state_d = DONE;
                else if (last_trip) state_d = WAIT_BUF;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zbuf      <= '0;
            ptr       <= '0;
            poly      <= '0;
            coef_cnt  <= '0;
            need_more <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        coef_cnt  <= '0;
                        ptr       <= '0;
                        need_more <= 1'b0;
                    end
                end
                WAIT_BUF: begin
                    if (in_valid) begin
                        zbuf <= Z_in;
                        ptr  <= '0;
                    end
                end
                SAMPLE: begin
                    if (acc1) poly[12*int'(coef_cnt) +: 12] <= d1;
                    if (acc2) poly[12*int'(cnt1) +: 12]     <= d2;
                    coef_cnt <= cnt2;
                    ptr      <= ptr + 1'b1;
                    if ((cnt2 != NC) && last_trip) need_more <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Directed bench for rej_uniform_sampler: table of whole-buffer runs plus boundary and reset sequences.
module tb_rej_uniform_sampler;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [0:3071]     z_in;
    logic [0:3071]     poly_w;
    logic [8:0]        coef_cnt;
    logic              need_more;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    rej_uniform_sampler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Z_in      (z_in),
        .poly      (poly_w),
        .coef_cnt  (coef_cnt),
        .need_more (need_more),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_start;
        logic [23:0] triple;
        bit          exp_done;
        int          exp_cyc;
        int          exp_cnt;
        bit          exp_nm;
        int          ia;
        int          va;
        int          ib;
        int          vb;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [0:3071] fill(input logic [23:0] t);
        logic [0:3071] b;
        for (int k = 0; k < 128; k++) b[24*k +: 24] = t;
        return b;
    endfunction

    function automatic int coef(input int i);
        return {20'd0, poly_w[12*i +: 12]};
    endfunction

    // Entered and left at a falling edge; handshake cycle is the one ending at the first rising edge.
    task automatic run_buf(input string nm, input bit do_start, input logic [0:3071] b,
                           input bit exp_done, input int exp_cyc, input int exp_cnt, input bit exp_nm);
        int cyc;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({nm, "_nm_clear"}, int'(need_more), 0);
        end
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        z_in     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        z_in     = ~b;
        cyc      = 1;
        while (!done && !in_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_cycles"}, cyc, exp_cyc);
        chk({nm, "_done"}, int'(done), int'(exp_done));
        chk({nm, "_coef_cnt"}, int'(coef_cnt), exp_cnt);
        if (!exp_done) chk({nm, "_need_more"}, int'(need_more), int'(exp_nm));
        else begin
            @(negedge clk);
            chk({nm, "_done_pulse"}, int'(done), 0);
            chk({nm, "_idle"}, int'(busy), 0);
            chk({nm, "_cnt_hold"}, int'(coef_cnt), exp_cnt);
        end
    endtask

    initial begin
        logic [0:3071] b;

        vt[0] = '{1'b1, 24'h000000, 1'b1, 129, 256, 1'b0,   0,    0, 255,    0};
        vt[1] = '{1'b1, 24'h000D00, 1'b1, 129, 256, 1'b0, 254, 3328, 255,    0};
        vt[2] = '{1'b1, 24'hFFFFFF, 1'b0, 129,   0, 1'b1,   0, 3328,   1,    0};
        vt[3] = '{1'b0, 24'h000000, 1'b1, 129, 256, 1'b0,   0,    0, 254,    0};
        vt[4] = '{1'b1, 24'h000D00, 1'b1, 129, 256, 1'b0,   0, 3328,   1,    0};
        vt[5] = '{1'b1, 24'h010D00, 1'b0, 129, 128, 1'b1, 127,    0, 128, 3328};
        vt[6] = '{1'b0, 24'h000000, 1'b1,  65, 256, 1'b0, 128,    0, 255,    0};

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        z_in     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_coef_cnt", int'(coef_cnt), 0);
        chk("rst_poly_nonzero", int'(|poly_w), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_buf($sformatf("vec%0d", i), vt[i].do_start, fill(vt[i].triple),
                    vt[i].exp_done, vt[i].exp_cyc, vt[i].exp_cnt, vt[i].exp_nm);
            chk($sformatf("vec%0d_coef%0d", i, vt[i].ia), coef(vt[i].ia), vt[i].va);
            chk($sformatf("vec%0d_coef%0d", i, vt[i].ib), coef(vt[i].ib), vt[i].vb);
        end

        // Reach 255 coefficients, then the last slot takes d1 only.
        b = fill(24'h000D00);
        b[24*127 +: 24] = 24'h0000FF;
        run_buf("bnd1", 1'b1, b, 1'b0, 129, 255, 1'b1);
        chk("bnd1_coef252", coef(252), 3328);
        chk("bnd1_coef254", coef(254), 0);
        b = fill(24'hFFFFFF);
        b[0 +: 24] = 24'h000D00;
        run_buf("bnd2", 1'b0, b, 1'b1, 2, 256, 1'b0);
        chk("bnd2_coef255", coef(255), 3328);

        // start and in_valid during SAMPLE must not disturb the run, then abort with reset.
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        z_in     = fill(24'h000000);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 5) begin
                start    = 1'b1;
                in_valid = 1'b1;
                z_in     = fill(24'hFFFFFF);
            end
            if (j == 8) begin
                start    = 1'b0;
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("mid_coef_cnt", int'(coef_cnt), 40);
        chk("mid_busy", int'(busy), 1);
        chk("mid_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("abort_coef_cnt", int'(coef_cnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_need_more", int'(need_more), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_poly_nonzero", int'(|poly_w), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_buf("post", 1'b1, fill(24'h000D00), 1'b1, 129, 256, 1'b0);
        chk("post_coef0", coef(0), 3328);
        chk("post_coef1", coef(1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
